// File: rtl/pcpi_div_ctrl_if.sv
// pcpi_div_ctrl_if
//   Bundles the PicoRV32 PCPI signals and the divider handshake that
//   pcpi_div_ctrl sits between.
//   modport slave  : the controller side (consumes the PCPI request and the
//                    divider results, produces the PCPI response and the
//                    divider start/operands).
//   modport master : the environment side (core plus divider datapath).
//
//   Handshake summary: the core raises pcpi_valid with a fixed pcpi_insn and
//   operands and holds them until it sees pcpi_ready. pcpi_ready and pcpi_wr
//   pulse for one cycle with pcpi_rd valid. div_start is a level: the divider
//   runs while it is high. div_finished is held high until div_start falls.
interface pcpi_div_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             pcpi_valid;
   logic [31:0]      pcpi_insn;
   logic [WIDTH-1:0] pcpi_rs1;
   logic [WIDTH-1:0] pcpi_rs2;
   logic             pcpi_wr;
   logic [WIDTH-1:0] pcpi_rd;
   logic             pcpi_wait;
   logic             pcpi_ready;
   logic             div_start;
   logic             div_unsigned;
   logic [WIDTH-1:0] div_a;
   logic [WIDTH-1:0] div_b;
   logic [WIDTH-1:0] div_z;
   logic [WIDTH-1:0] div_r;
   logic             div_finished;

   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  div_z, div_r, div_finished,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      output div_start, div_unsigned, div_a, div_b
   );

   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output div_z, div_r, div_finished,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      input  div_start, div_unsigned, div_a, div_b
   );
endinterface

// File: rtl/pcpi_div_ctrl.sv
// pcpi_div_ctrl
//   PCPI front-end for an iterative divider. Decodes RV32M DIV/DIVU/REM/REMU,
//   latches the operands, runs the divider start/finished handshake and
//   returns quotient or remainder. Divide-by-zero and signed overflow are
//   answered directly without starting the divider.
//   Ports:
//     clk       rising-edge clock
//     resetn    synchronous active-low reset
//     bus       pcpi_div_ctrl_if.slave (PCPI request/response + divider)
//     dbg_state current FSM state (0 IDLE, 1 ISSUE, 2 RESP, 3 DRAIN)
module pcpi_div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   pcpi_div_ctrl_if.slave        bus,
   output logic [1:0]            dbg_state
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   state_t           state;
   state_t           state_next;
   logic [1:0]       op;        // {select remainder, unsigned}
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] rd_q;
   logic             match;
   logic             accept;
   logic             rd_load;
   logic [WIDTH-1:0] rd_next;

   assign match = (bus.pcpi_insn[6:0] == 7'b0110011) &&
                  (bus.pcpi_insn[31:25] == 7'b0000001) &&
                  bus.pcpi_insn[14];

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      rd_load    = 1'b0;
      rd_next    = '0;
      case (state)
         S_IDLE: begin
            // A still-high div_finished means the divider has not yet
            // cleared from the previous run; wait it out.
            if (bus.pcpi_valid && match && !bus.div_finished) begin
               accept = 1'b1;
               if (bus.pcpi_rs2 == '0) begin
                  rd_load    = 1'b1;
                  rd_next    = bus.pcpi_insn[13] ? bus.pcpi_rs1 : ALL_ONES;
                  state_next = S_RESP;
               end else if (!bus.pcpi_insn[12] && (bus.pcpi_rs1 == MIN_NEG) &&
                            (bus.pcpi_rs2 == ALL_ONES)) begin
                  rd_load    = 1'b1;
                  rd_next    = bus.pcpi_insn[13] ? '0 : MIN_NEG;
                  state_next = S_RESP;
               end else begin
                  state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            // A dropped request wins over a simultaneous finish.
            if (!bus.pcpi_valid) begin
               state_next = S_DRAIN;
            end else if (bus.div_finished) begin
               rd_load    = 1'b1;
               rd_next    = op[1] ? bus.div_r : bus.div_z;
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            state_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Hold off until the divider has dropped div_finished so a
            // still-held instruction is not accepted and run a second time.
            if (!bus.div_finished) state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
         op    <= 2'b00;
         a_q   <= '0;
         b_q   <= '0;
         rd_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            op  <= bus.pcpi_insn[13:12];
            a_q <= bus.pcpi_rs1;
            b_q <= bus.pcpi_rs2;
         end
         if (rd_load) rd_q <= rd_next;
      end
   end

   assign bus.pcpi_wait    = bus.pcpi_valid && match && (state != S_RESP);
   assign bus.pcpi_ready   = (state == S_RESP);
   assign bus.pcpi_wr      = (state == S_RESP);
   assign bus.pcpi_rd      = rd_q;
   assign bus.div_start    = (state == S_ISSUE);
   assign bus.div_unsigned = op[0];
   assign bus.div_a        = a_q;
   assign bus.div_b        = b_q;
   assign dbg_state        = state;
endmodule

// File: tb/tb_pcpi_div_ctrl.sv
module tb_pcpi_div_ctrl;
   localparam int WIDTH   = 32;
   localparam int DIV_LAT = 4;

   logic       clk;
   logic       resetn;
   logic [1:0] dbg_state;
   int         pass_cnt;
   int         total_cnt;
   int         div_cnt;

   pcpi_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

   pcpi_div_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider stand-in: finishes DIV_LAT+1 edges after start rises, holds
   // div_finished while div_start stays high, clears one edge after it falls.
   always @(posedge clk) begin
      if (!resetn) begin
         bus.div_finished <= 1'b0;
         bus.div_z        <= '0;
         bus.div_r        <= '0;
         div_cnt          <= 0;
      end else if (!bus.div_start) begin
         bus.div_finished <= 1'b0;
         div_cnt          <= 0;
      end else if (!bus.div_finished) begin
         if (div_cnt == DIV_LAT) begin
            bus.div_finished <= 1'b1;
            if (bus.div_b != '0) begin
               if (bus.div_unsigned) begin
                  bus.div_z <= bus.div_a / bus.div_b;
                  bus.div_r <= bus.div_a % bus.div_b;
               end else begin
                  bus.div_z <= $signed(bus.div_a) / $signed(bus.div_b);
                  bus.div_r <= $signed(bus.div_a) % $signed(bus.div_b);
               end
            end
         end else begin
            div_cnt <= div_cnt + 1;
         end
      end
   end

   function automatic logic [31:0] mk_insn(input logic [2:0] f3);
      return {7'b0000001, 10'b0, f3, 5'b0, 7'b0110011};
   endfunction

   task automatic test_reset();
      resetn         = 1'b0;
      bus.pcpi_valid = 1'b0;
      bus.pcpi_insn  = '0;
      bus.pcpi_rs1   = '0;
      bus.pcpi_rs2   = '0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({bus.pcpi_wr, bus.pcpi_ready, bus.div_start, bus.div_unsigned, bus.pcpi_wait} !== 5'b0)
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {bus.pcpi_wr, bus.pcpi_ready, bus.div_start, bus.div_unsigned, bus.pcpi_wait});
      else pass_cnt++;
      total_cnt++;
      if ({bus.pcpi_rd, bus.div_a, bus.div_b} !== 96'd0)
         $display("FAIL reset_data: got %h %h %h expected 0", bus.pcpi_rd, bus.div_a, bus.div_b);
      else pass_cnt++;
      total_cnt++;
      if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
      else pass_cnt++;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   // Issues one matching instruction and checks the full response sequence.
   task automatic test_op(input string name, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] exp, input bit fast, input bit hold_extra);
      int   cyc;
      bit   got;
      bit   saw_start;
      bit   extra_ready;
      logic uns_seen;
      got = 0; saw_start = 0; extra_ready = 0; uns_seen = 1'bx; cyc = 0;
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = mk_insn(f3);
      bus.pcpi_rs1   = rs1;
      bus.pcpi_rs2   = rs2;
      #1;
      total_cnt++;
      if (bus.pcpi_wait !== 1'b1) $display("FAIL %s_wait: got %b expected 1", name, bus.pcpi_wait);
      else pass_cnt++;
      while (!got && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.div_start === 1'b1) begin
            if (!saw_start) uns_seen = bus.div_unsigned;
            saw_start = 1;
         end
         if (bus.pcpi_ready === 1'b1) got = 1;
      end
      total_cnt++;
      if (!got) $display("FAIL %s_ready: got none in %0d cycles expected pulse", name, cyc);
      else pass_cnt++;
      total_cnt++;
      if (bus.pcpi_wr !== 1'b1) $display("FAIL %s_wr: got %b expected 1", name, bus.pcpi_wr);
      else pass_cnt++;
      total_cnt++;
      if (bus.pcpi_rd !== exp) $display("FAIL %s_rd: got %h expected %h", name, bus.pcpi_rd, exp);
      else pass_cnt++;
      if (fast) begin
         total_cnt++;
         if (saw_start || cyc != 1)
            $display("FAIL %s_fast: got start=%0d latency=%0d expected start=0 latency=1", name, saw_start, cyc);
         else pass_cnt++;
      end else begin
         total_cnt++;
         if (!saw_start || uns_seen !== f3[0])
            $display("FAIL %s_issue: got start=%0d unsigned=%b expected start=1 unsigned=%b",
                     name, saw_start, uns_seen, f3[0]);
         else pass_cnt++;
      end
      if (!hold_extra) bus.pcpi_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({bus.pcpi_ready, bus.pcpi_wr} !== 2'b00)
         $display("FAIL %s_pulse: got %b expected 00", name, {bus.pcpi_ready, bus.pcpi_wr});
      else pass_cnt++;
      if (hold_extra) begin
         total_cnt++;
         if ({dbg_state, bus.pcpi_wait} !== 3'b111)
            $display("FAIL %s_drain_hold: got state=%0d wait=%b expected state=3 wait=1",
                     name, dbg_state, bus.pcpi_wait);
         else pass_cnt++;
         bus.pcpi_valid = 1'b0;
      end
      cyc = 0;
      while (dbg_state !== 2'd0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.pcpi_ready === 1'b1) extra_ready = 1;
      end
      repeat (4) begin
         @(negedge clk);
         if (bus.pcpi_ready === 1'b1) extra_ready = 1;
      end
      total_cnt++;
      if (extra_ready || dbg_state !== 2'd0)
         $display("FAIL %s_settle: got extra_ready=%0d state=%0d expected 0 0", name, extra_ready, dbg_state);
      else pass_cnt++;
      total_cnt++;
      if (bus.pcpi_rd !== exp) $display("FAIL %s_rd_hold: got %h expected %h", name, bus.pcpi_rd, exp);
      else pass_cnt++;
   endtask

   task automatic test_non_match();
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = mk_insn(3'b000);
      bus.pcpi_rs1   = 32'd6;
      bus.pcpi_rs2   = 32'd7;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({bus.pcpi_wait, bus.pcpi_ready, bus.div_start, dbg_state} !== 5'b0)
            $display("FAIL mul_ignored: cycle %0d got %b expected 00000", i,
                     {bus.pcpi_wait, bus.pcpi_ready, bus.div_start, dbg_state});
         else pass_cnt++;
      end
      bus.pcpi_valid = 1'b0;
      @(negedge clk);
   endtask

   // race=0: drop pcpi_valid early in ISSUE; race=1: drop it in the cycle
   // div_finished is already high.
   task automatic test_abort(input string name, input bit race);
      int cyc;
      bit seen_ready;
      cyc = 0; seen_ready = 0;
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = mk_insn(3'b101);
      bus.pcpi_rs1   = 32'd1000;
      bus.pcpi_rs2   = 32'd3;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.pcpi_ready === 1'b1) seen_ready = 1;
         if (race ? (bus.div_finished === 1'b1) : (bus.div_start === 1'b1 && cyc >= 2)) break;
      end
      total_cnt++;
      if (dbg_state !== 2'd1) $display("FAIL %s_in_issue: got %0d expected 1", name, dbg_state);
      else pass_cnt++;
      bus.pcpi_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({dbg_state, bus.pcpi_ready, bus.div_start} !== 4'b1100)
         $display("FAIL %s_drain: got %b expected 1100", name, {dbg_state, bus.pcpi_ready, bus.div_start});
      else pass_cnt++;
      cyc = 0;
      while (dbg_state !== 2'd0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.pcpi_ready === 1'b1) seen_ready = 1;
      end
      total_cnt++;
      if (seen_ready || dbg_state !== 2'd0)
         $display("FAIL %s_no_resp: got ready=%0d state=%0d expected 0 0", name, seen_ready, dbg_state);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int cyc;
      cyc = 0;
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = mk_insn(3'b101);
      bus.pcpi_rs1   = 32'd50;
      bus.pcpi_rs2   = 32'd9;
      while (bus.div_start !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      total_cnt++;
      if (bus.div_start !== 1'b1) $display("FAIL rstmid_start: got %b expected 1", bus.div_start);
      else pass_cnt++;
      resetn         = 1'b0;
      bus.pcpi_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({bus.div_start, bus.pcpi_ready, bus.pcpi_wr, bus.div_unsigned, dbg_state} !== 6'b0)
         $display("FAIL rstmid_ctrl: got %b expected 000000",
                  {bus.div_start, bus.pcpi_ready, bus.pcpi_wr, bus.div_unsigned, dbg_state});
      else pass_cnt++;
      total_cnt++;
      if ({bus.pcpi_rd, bus.div_a, bus.div_b} !== 96'd0)
         $display("FAIL rstmid_data: got %h %h %h expected 0", bus.pcpi_rd, bus.div_a, bus.div_b);
      else pass_cnt++;
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_op("divu",       3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
      test_op("remu",       3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
      test_op("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
      test_op("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
      test_op("divu_zero",  3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
      test_op("remu_zero",  3'b111, 32'h00001234, 32'd0,        32'h00001234, 1'b1, 1'b0);
      test_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
      test_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      test_op("divu_ovf_pat", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
      test_non_match();
      test_op("b2b_div",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b1);
      test_op("b2b_fast",   3'b111, 32'd77,       32'd0,        32'd77,       1'b1, 1'b1);
      test_abort("abort", 1'b0);
      test_abort("abort_race", 1'b1);
      test_reset_mid();
      test_op("after_rst",  3'b100, 32'd45,       32'hFFFFFFFB, 32'hFFFFFFF7, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
